// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared definitions for the data-memory responder.
//   - DMEM_WORD_W / DMEM_BE_W : data word width and byte-enable width
//   - DMEM_STATE_W            : width of the one-hot responder FSM state
//   - dmem_state_e            : DMEM_IDLE / DMEM_WAIT / DMEM_RESP encodings
//   - dmem_be_merge()         : byte-lane merge of new data over old data
package dmem_responder_pkg;

    localparam int DMEM_WORD_W  = 32;
    localparam int DMEM_BE_W    = DMEM_WORD_W / 8;
    localparam int DMEM_STATE_W = 3;

    typedef enum logic [DMEM_STATE_W-1:0] {
        DMEM_IDLE = 3'b001,
        DMEM_WAIT = 3'b010,
        DMEM_RESP = 3'b100
    } dmem_state_e;

    function automatic logic [DMEM_WORD_W-1:0] dmem_be_merge(
        input logic [DMEM_WORD_W-1:0] old_w,
        input logic [DMEM_WORD_W-1:0] new_w,
        input logic [DMEM_BE_W-1:0]   be
    );
        logic [DMEM_WORD_W-1:0] r;
        r = old_w;
        for (int i = 0; i < DMEM_BE_W; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-organised, byte-writable RAM.
//   CLK   in  clock; write commits on rising edge
//   WE    in  write strobe
//   WADDR in  write word index
//   WDATA in  write data
//   BE    in  byte-lane enables (bit i -> byte lane i)
//   RADDR in  read word index
//   RDATA out combinational read data; registered by the responder
// Contents are not reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                   CLK,
    input  logic                   WE,
    input  logic [IDX_W-1:0]       WADDR,
    input  logic [DMEM_WORD_W-1:0] WDATA,
    input  logic [DMEM_BE_W-1:0]   BE,
    input  logic [IDX_W-1:0]       RADDR,
    output logic [DMEM_WORD_W-1:0] RDATA
);

    logic [DMEM_WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge CLK) begin
        if (WE) begin
            for (int i = 0; i < DMEM_BE_W; i++)
                if (BE[i]) mem[WADDR][8*i +: 8] <= WDATA[8*i +: 8];
        end
    end

    assign RDATA = mem[RADDR];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data interface.
// Loads: DATA_REQ (held by the core) starts a read in IDLE, waits
// WAIT_CYCLES, then a registered one-cycle DATA_VALID returns the word.
// Stores: DATA_WRITE_ENABLE commits DATA_WDATA lanes selected by DATA_BE
// in a single cycle, in any FSM state, with no response.
//   CLK                in  clock, rising edge
//   RES_N              in  asynchronous active-low reset
//   DATA_REQ           in  load request
//   DATA_WRITE_ENABLE  in  store strobe
//   DATA_ADDR          in  byte address ([1:0] ignored)
//   DATA_WDATA         in  store data
//   DATA_BE            in  store byte enables
//   DATA_RDATA         out load data (holds until next response)
//   DATA_VALID         out one-cycle load response
//   DATA_ERR           out out-of-range load flag (with DATA_VALID)
// Build option DMEM_BOUNDS_CHECK_EN: out-of-range loads return 0 with
// DATA_ERR=1 and out-of-range stores are dropped; otherwise the word index
// wraps modulo DEPTH_WORDS and DATA_ERR is tied low.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   CLK,
    input  logic                   RES_N,
    input  logic                   DATA_REQ,
    input  logic                   DATA_WRITE_ENABLE,
    input  logic [31:0]            DATA_ADDR,
    input  logic [DMEM_WORD_W-1:0] DATA_WDATA,
    input  logic [DMEM_BE_W-1:0]   DATA_BE,
    output logic [DMEM_WORD_W-1:0] DATA_RDATA,
    output logic                   DATA_VALID,
    output logic                   DATA_ERR
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] idx_q, idx_d;
    logic [29:0] req_idx;
    logic        start;
    logic        load_oor, st_oor, arr_we;
    logic [DMEM_WORD_W-1:0] arr_rdata, fwd_rdata;

    assign req_idx = DATA_ADDR[31:2];
    // A store wins over a simultaneous request; the held request starts next cycle.
    assign start   = (state_q == DMEM_IDLE) && DATA_REQ && !DATA_WRITE_ENABLE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            DMEM_IDLE: if (start) begin
                idx_d   = req_idx;
                cnt_d   = WAIT_INIT;
                state_d = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_RESP;
            end
            // The counter reaches 0 at the end of this cycle when it reads 1,
            // so WAIT lasts exactly WAIT_CYCLES cycles.
            DMEM_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = DMEM_RESP;
            end
            DMEM_RESP: state_d = DMEM_IDLE;
            default:   state_d = DMEM_IDLE;
        endcase
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    assign load_oor = ({2'b00, idx_d}   >= 32'(DEPTH_WORDS));
    assign st_oor   = ({2'b00, req_idx} >= 32'(DEPTH_WORDS));
`else
    assign load_oor = 1'b0;
    assign st_oor   = 1'b0;
`endif

    assign arr_we = DATA_WRITE_ENABLE && !st_oor;

    // Read uses idx_d so the zero-wait case (index latched on the same edge)
    // and the latched case share one path.
    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
        .CLK   (CLK),
        .WE    (arr_we),
        .WADDR (req_idx[IDX_W-1:0]),
        .WDATA (DATA_WDATA),
        .BE    (DATA_BE),
        .RADDR (idx_d[IDX_W-1:0]),
        .RDATA (arr_rdata)
    );

    // A store committing on the same edge that captures the load must be
    // visible in the response, so merge its lanes over the array read.
    always_comb begin
        fwd_rdata = arr_rdata;
        if (arr_we && (req_idx[IDX_W-1:0] == idx_d[IDX_W-1:0]))
            fwd_rdata = dmem_be_merge(arr_rdata, DATA_WDATA, DATA_BE);
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q    <= DMEM_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            DATA_VALID <= 1'b0;
            DATA_RDATA <= '0;
            DATA_ERR   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (state_d == DMEM_RESP) begin
                DATA_VALID <= 1'b1;
                DATA_RDATA <= load_oor ? '0 : fwd_rdata;
                DATA_ERR   <= load_oor;
            end else begin
                DATA_VALID <= 1'b0;
                DATA_ERR   <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{1'b0, DATA_ADDR[1:0], idx_d, req_idx};

endmodule
